uart_tx_fifo_drain: RTL and testbench
=====================================

# uart_tx_fifo_drain

Read-side consumer of the asynchronous FIFO, running in the UART transmit clock domain. Pops one word at a time from the FIFO read port and serialises it as a UART frame: start bit, data LSB-first, optional parity, stop bit. One bit is sent per `CLK` cycle, because `CLK` is the baud-rate tick clock from the clock divider. Frames go out back-to-back with no idle gap while the FIFO stays non-empty.

## Interface
- `WIDTH`, default 8: data word width; must match the FIFO `WIDTH`.
- `CLK` input 1: transmit/baud clock; the FIFO read clock is tied to the same net.
- `RST` input 1: synchronous, active-high reset.
- `FIFO_EMPTY` input 1: FIFO `EMPTY` flag, registered in the `CLK` domain.
- `FIFO_RD_DATA` input `WIDTH`: FIFO head word, valid whenever `FIFO_EMPTY`=0 (first-word-fall-through).
- `PAR_EN` input 1: 1 = append a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `FIFO_R_INC` output 1: pop strobe to the FIFO `R_INC`; a single-cycle pulse per word.
- `TX_OUT` output 1: serial line, idle high, registered.
- `BUSY` output 1: high while a frame is on the line, registered.

## Operation
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- Pop condition, combinational: `FIFO_R_INC` = (state==`IDLE` or state==`STOP`) & !`FIFO_EMPTY` & !`RST`.
- On a pop edge, the block:
  - latches `FIFO_RD_DATA` into the shift register;
  - latches `PAR_EN`/`PAR_TYP` into the frame config;
  - computes parity: even = XOR of the word, odd = its inverse;
  - moves state to `START`.
- `START`: `TX_OUT`=0 for one cycle, then `DATA`.
- `DATA`: shifts out bits 0..`WIDTH`-1, one per cycle, using a bit counter of width $clog2(`WIDTH`).
  - After bit `WIDTH`-1, go to `PARITY` if latched `PAR_EN`, else `STOP`.
- `PARITY`: drives the latched parity bit for one cycle, then `STOP`.
- `STOP`: `TX_OUT`=1 for one cycle, then:
  - if a pop occurs in this cycle, go to `START` (back-to-back frame);
  - otherwise go to `IDLE`.
- `IDLE`: `TX_OUT`=1, `BUSY`=0.
- Changing `PAR_EN`/`PAR_TYP` mid-frame has no effect until the next pop.
- There is never a second pop inside a frame; `FIFO_R_INC` is 0 in `START`, `DATA` and `PARITY`.

## Timing
- Reset (any cycle, including mid-frame): on the next edge, state=`IDLE`, `TX_OUT`=1, `BUSY`=0, bit counter=0, shift register=0.
  - `FIFO_R_INC` is forced to 0 while `RST`=1.
  - A word already popped is dropped and not retransmitted.
- Latency: `FIFO_EMPTY` is low in cycle t while the block is `IDLE`. `FIFO_R_INC`=1 in cycle t, and the start bit appears on `TX_OUT` in cycle t+1.
- Frame length: 2+`WIDTH` cycles, plus 1 when parity is enabled. For `WIDTH`=8 that is 10 or 11 cycles.
- `BUSY`=1 from the start-bit cycle through the stop-bit cycle inclusive. With back-to-back frames, `BUSY` stays 1 continuously.
- FIFO becomes empty during the stop bit: no pop, `IDLE` next cycle, `TX_OUT` stays 1.
- `FIFO_EMPTY` deasserts on the stop-bit cycle: the pop happens in that cycle and the next start bit follows with zero gap.
- `FIFO_EMPTY` glitch-free requirement: the FIFO updates `EMPTY` one cycle after a pop. This is safe because the earliest next pop is at least `WIDTH`+2 cycles later.
- `TX_OUT` and `BUSY` come straight from flops; `FIFO_R_INC` is the only combinational output.

## Test plan
- Reset behaviour: hold `RST`=1 for 3 cycles with `FIFO_EMPTY`=0 -> `FIFO_R_INC`=0, `TX_OUT`=1, `BUSY`=0 throughout. After release, pop on the first cycle and start bit on the next.
- Single word, no parity: 0xA5, `PAR_EN`=0 -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1, then idle 1; `BUSY` high for exactly 10 cycles; exactly one `FIFO_R_INC` pulse.
- Parity: 0x03 with even parity -> parity bit 0; 0x07 with odd parity -> parity bit 0; 0x07 with even parity -> parity bit 1. Frame is 11 cycles.
- Back-to-back: FIFO holds 0x11, 0x22, 0x33 -> three contiguous 10-cycle frames; `BUSY` held high for 30 cycles; pops occur only in the stop-bit cycles (plus the initial `IDLE` pop).
- Mid-frame changes:
  - toggle `PAR_EN` during `DATA` -> current frame keeps its latched config; the next frame uses the new one;
  - assert `RST` at data bit 4 -> `TX_OUT`=1 on the next edge and `IDLE`; the aborted word is not resent.
- Empty at stop: FIFO empties after the first word -> `IDLE` after the stop bit with no spurious `FIFO_R_INC`. A write later produces a start bit exactly 1 cycle after `FIFO_EMPTY` falls.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// rtl/uart_tx_fifo_drain_if.sv - FIFO read port and serial line bundle for the UART drain
interface uart_tx_fifo_drain_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             par_en;
    logic             par_typ;
    logic             fifo_r_inc;
    logic             tx_out;
    logic             busy;

    modport master (
        output fifo_empty,
        output fifo_rd_data,
        output par_en,
        output par_typ,
        input  fifo_r_inc,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  fifo_empty,
        input  fifo_rd_data,
        input  par_en,
        input  par_typ,
        output fifo_r_inc,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter draining a FWFT FIFO, one bit per baud clock
module uart_tx_fifo_drain #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_drain_if.slave  bus
);
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             par_en_q, par_en_nxt;
    logic             par_bit_q, par_bit_nxt;
    logic             tx_q, tx_nxt;
    logic             busy_q, busy_nxt;
    logic             pop;

    // A pop is only allowed when the line is free or about to be (stop bit),
    // which keeps frames back-to-back without ever popping twice per frame.
    assign pop = ((state == IDLE) || (state == STOP)) && !bus.fifo_empty && !rst;

    assign bus.fifo_r_inc = pop;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = busy_q;

    // Next-state and next-line-value logic; tx/busy are precomputed so they leave from flops.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_en_nxt  = par_en_q;
        par_bit_nxt = par_bit_q;
        tx_nxt      = tx_q;

        case (state)
            IDLE, STOP: begin
                if (pop) begin
                    state_nxt   = START;
                    shreg_nxt   = bus.fifo_rd_data;
                    par_en_nxt  = bus.par_en;
                    par_bit_nxt = (^bus.fifo_rd_data) ^ bus.par_typ;
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            START: begin
                state_nxt   = DATA;
                tx_nxt      = shreg[0];
                shreg_nxt   = shreg >> 1;
                bit_cnt_nxt = '0;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
                    if (par_en_q) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit_q;
                    end else begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                    tx_nxt      = shreg[0];
                    shreg_nxt   = shreg >> 1;
                end
            end
            PARITY: begin
                state_nxt = STOP;
                tx_nxt    = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and datapath registers; reset drops any word already popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            par_en_q  <= par_en_nxt;
            par_bit_q <= par_bit_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain
module tb_uart_tx_fifo_drain;
    logic clk;
    logic rst;

    uart_tx_fifo_drain_if #(.WIDTH(8)) bus ();

    uart_tx_fifo_drain #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        int          len;
        logic [10:0] frame;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] fq[$];
    bit         mq[$];
    bit         tx_log[$];
    bit         busy_log[$];
    int         pop_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: check line against the model, apply inputs, check the pop, advance the model.
    task automatic cycle(input logic r, input logic pe, input logic pt);
        logic       exp_pop;
        logic [7:0] w;
        bit         par;
        @(negedge clk);
        chk("tx_out", {31'b0, bus.tx_out}, {31'b0, (mq.size() != 0) ? mq[0] : 1'b1});
        chk("busy",   {31'b0, bus.busy},   {31'b0, mq.size() != 0});
        tx_log.push_back(bus.tx_out);
        busy_log.push_back(bus.busy);
        rst              = r;
        bus.par_en       = pe;
        bus.par_typ      = pt;
        bus.fifo_empty   = (fq.size() == 0);
        bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        exp_pop = (mq.size() <= 1) && (fq.size() != 0) && !r;
        chk("fifo_r_inc", {31'b0, bus.fifo_r_inc}, {31'b0, exp_pop});
        if (bus.fifo_r_inc === 1'b1) pop_cnt++;
        if (mq.size() != 0) void'(mq.pop_front());
        if (r) mq.delete();
        if (exp_pop) begin
            w   = fq.pop_front();
            par = bit'($countones(w) % 2) ^ pt;
            mq.push_back(1'b0);
            for (int i = 0; i < 8; i++) mq.push_back(w[i]);
            if (pe) mq.push_back(par);
            mq.push_back(1'b1);
        end
    endtask

    task automatic run(input int n, input logic r, input logic pe, input logic pt);
        for (int i = 0; i < n; i++) cycle(r, pe, pt);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        busy_log.delete();
        pop_cnt = 0;
    endtask

    function automatic int busy_sum();
        int s = 0;
        foreach (busy_log[i]) s += int'(busy_log[i]);
        return s;
    endfunction

    vec_t vecs[6];

    initial begin
        logic [10:0] f;
        int          s;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'h34A};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 11, 11'h406};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 11, 11'h40E};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 11, 11'h60E};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 11, 11'h7FE};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 10, 11'h200};

        rst              = 1'b1;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 8'h00;
        bus.par_en       = 1'b0;
        bus.par_typ      = 1'b0;
        @(posedge clk);

        // Reset held with a non-empty FIFO: no pop, idle line, then pop on release.
        fq.push_back(8'h5A);
        clear_logs();
        run(3, 1'b1, 1'b0, 1'b0);
        chk("reset_no_pop", pop_cnt, 0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("release_pop", pop_cnt, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("release_start_bit", {31'b0, tx_log[4]}, 0);
        run(12, 1'b0, 1'b0, 1'b0);

        // Single-frame vectors: frame bits, length and pop count.
        foreach (vecs[k]) begin
            fq.push_back(vecs[k].data);
            clear_logs();
            run(14, 1'b0, vecs[k].pe, vecs[k].pt);
            f = '0;
            for (int i = 0; i < vecs[k].len; i++) f[i] = tx_log[1 + i];
            chk($sformatf("frame_%0d", k), {21'b0, f}, {21'b0, vecs[k].frame});
            chk($sformatf("busy_len_%0d", k), busy_sum(), vecs[k].len);
            chk($sformatf("pops_%0d", k), pop_cnt, 1);
        end

        // Back-to-back: three contiguous frames.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        clear_logs();
        run(34, 1'b0, 1'b0, 1'b0);
        s = 0;
        for (int i = 1; i <= 30; i++) s += int'(busy_log[i]);
        chk("b2b_busy_contig", s, 30);
        chk("b2b_busy_total", busy_sum(), 30);
        chk("b2b_pops", pop_cnt, 3);

        // Parity enable toggled mid-frame: applies to the next frame only.
        fq.push_back(8'h5A);
        fq.push_back(8'h3C);
        clear_logs();
        run(4, 1'b0, 1'b0, 1'b0);
        run(30, 1'b0, 1'b1, 1'b0);
        chk("toggle_busy_total", busy_sum(), 21);
        chk("toggle_second_parity", {31'b0, tx_log[20]}, 0);
        chk("toggle_second_stop", {31'b0, tx_log[21]}, 1);

        // Reset at data bit 4: frame aborted and the word is not resent.
        fq.push_back(8'hC3);
        clear_logs();
        run(6, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("abort_busy_mid", {31'b0, busy_log[6]}, 1);
        chk("abort_bit4", {31'b0, tx_log[6]}, 0);
        clear_logs();
        run(12, 1'b0, 1'b0, 1'b0);
        chk("abort_no_resend_pops", pop_cnt, 0);
        chk("abort_no_resend_busy", busy_sum(), 0);

        // FIFO empties at stop, then a later write starts a frame one cycle after empty falls.
        fq.push_back(8'h81);
        run(14, 1'b0, 1'b0, 1'b0);
        clear_logs();
        run(3, 1'b0, 1'b0, 1'b0);
        chk("idle_no_spurious_pop", pop_cnt, 0);
        fq.push_back(8'h42);
        clear_logs();
        run(2, 1'b0, 1'b0, 1'b0);
        chk("late_write_pop", pop_cnt, 1);
        chk("late_write_start", {31'b0, tx_log[1]}, 0);
        chk("late_write_busy", {31'b0, busy_log[1]}, 1);
        run(12, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the frame-level model.
        for (int c = 0; c < 600; c++) begin
            if (fq.size() < 4 && $urandom_range(0, 7) == 0) fq.push_back(8'($urandom));
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        run(80, 1'b0, 1'b0, 1'b0);
        chk("random_drained", fq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
